// File: rtl/native_to_axi4_master.sv
// native_to_axi4_master: bridges a native memory-controller style command/data
// port onto a single-beat AXI4 master. Only one transaction is in flight at a time.
// Optional feature: define NATIVE_TO_AXI4_RESP_CHECK_EN to latch a sticky
// resp_err flag on any non-OKAY B or R response. Without it, responses are ignored.
module native_to_axi4_master #(
  parameter int ADDR_WIDTH = 27,
  parameter int DATA_WIDTH = 256
) (
  input  logic                    axi_aclk,
  input  logic                    axi_resetn,
  // native command port
  input  logic [ADDR_WIDTH-1:0]   app_addr,
  input  logic [2:0]              app_cmd,
  input  logic                    app_en,
  output logic                    app_rdy,
  output logic                    init_calib_complete,
  // native write data
  input  logic [DATA_WIDTH-1:0]   app_wdf_data,
  input  logic [DATA_WIDTH/8-1:0] app_wdf_mask,
  input  logic                    app_wdf_wren,
  input  logic                    app_wdf_end,
  output logic                    app_wdf_rdy,
  // native read data
  output logic [DATA_WIDTH-1:0]   app_rd_data,
  output logic                    app_rd_data_valid,
  output logic                    app_rd_data_end,
  // AXI4 write address
  output logic [ADDR_WIDTH-1:0]   axi_awaddr,
  output logic [7:0]              axi_awlen,
  output logic [2:0]              axi_awsize,
  output logic [1:0]              axi_awburst,
  output logic                    axi_awvalid,
  input  logic                    axi_awready,
  // AXI4 write data
  output logic [DATA_WIDTH-1:0]   axi_wdata,
  output logic [DATA_WIDTH/8-1:0] axi_wstrb,
  output logic                    axi_wlast,
  output logic                    axi_wvalid,
  input  logic                    axi_wready,
  // AXI4 write response
  input  logic [1:0]              axi_bresp,
  input  logic                    axi_bvalid,
  output logic                    axi_bready,
  // AXI4 read address
  output logic [ADDR_WIDTH-1:0]   axi_araddr,
  output logic [7:0]              axi_arlen,
  output logic [2:0]              axi_arsize,
  output logic [1:0]              axi_arburst,
  output logic                    axi_arvalid,
  input  logic                    axi_arready,
  // AXI4 read data
  input  logic [DATA_WIDTH-1:0]   axi_rdata,
  input  logic [1:0]              axi_rresp,
  input  logic                    axi_rlast,
  input  logic                    axi_rvalid,
  output logic                    axi_rready,
  output logic                    resp_err
);

  localparam int          STRB_W = DATA_WIDTH / 8;
  localparam logic [2:0]  SIZE   = 3'($clog2(STRB_W));

  typedef enum logic [2:0] {
    S_NOP, S_IDLE, S_WR_DATA, S_WR_ADDR_DATA, S_WR_RESP, S_RD_ADDR, S_RD_DATA
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_W-1:0]     r_mask;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_init, r_app_rdy, r_wdf_rdy, r_rd_vld;
  logic                  r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready;
`ifdef NATIVE_TO_AXI4_RESP_CHECK_EN
  logic                  r_resp_err;
`endif

  // rlast is meaningless for single-beat reads; wdf_end carries no extra info here
  wire w_unused = ^{axi_rlast, app_wdf_end, axi_bresp, axi_rresp};

  // Main FSM: every output is a register updated together with the state
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      r_state   <= S_NOP;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_mask    <= '0;
      r_rdata   <= '0;
      r_init    <= 1'b0;
      r_app_rdy <= 1'b0;
      r_wdf_rdy <= 1'b0;
      r_rd_vld  <= 1'b0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
`ifdef NATIVE_TO_AXI4_RESP_CHECK_EN
      r_resp_err <= 1'b0;
`endif
    end else begin
      r_rd_vld <= 1'b0;  // read-return strobe is a one-cycle pulse
      case (r_state)
        S_NOP: begin
          r_state   <= S_IDLE;
          r_init    <= 1'b1;
          r_app_rdy <= 1'b1;
        end
        S_IDLE: begin
          if (app_en) begin
            case (app_cmd)
              3'd0: begin
                r_addr    <= app_addr;
                r_app_rdy <= 1'b0;
                r_wdf_rdy <= 1'b1;
                r_state   <= S_WR_DATA;
              end
              3'd1: begin
                r_addr    <= app_addr;
                r_app_rdy <= 1'b0;
                r_arvalid <= 1'b1;
                r_state   <= S_RD_ADDR;
              end
              default: ;  // unsupported command: swallowed, stay ready
            endcase
          end
        end
        S_WR_DATA: begin
          if (app_wdf_wren) begin
            r_wdata   <= app_wdf_data;
            r_mask    <= app_wdf_mask;
            r_wdf_rdy <= 1'b0;
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
            r_state   <= S_WR_ADDR_DATA;
          end
        end
        S_WR_ADDR_DATA: begin
          if (axi_awready) r_awvalid <= 1'b0;
          if (axi_wready)  r_wvalid  <= 1'b0;
          // a channel is done if it already dropped valid or handshakes now
          if ((!r_awvalid || axi_awready) && (!r_wvalid || axi_wready)) begin
            r_bready <= 1'b1;
            r_state  <= S_WR_RESP;
          end
        end
        S_WR_RESP: begin
          if (axi_bvalid) begin
            r_bready  <= 1'b0;
            r_app_rdy <= 1'b1;
            r_state   <= S_IDLE;
`ifdef NATIVE_TO_AXI4_RESP_CHECK_EN
            if (axi_bresp != 2'b00) r_resp_err <= 1'b1;
`endif
          end
        end
        S_RD_ADDR: begin
          if (axi_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (axi_rvalid) begin
            r_rdata   <= axi_rdata;
            r_rready  <= 1'b0;
            r_rd_vld  <= 1'b1;
            r_app_rdy <= 1'b1;
            r_state   <= S_IDLE;
`ifdef NATIVE_TO_AXI4_RESP_CHECK_EN
            if (axi_rresp != 2'b00) r_resp_err <= 1'b1;
`endif
          end
        end
        default: r_state <= S_NOP;
      endcase
    end
  end

  assign app_rdy             = r_app_rdy;
  assign init_calib_complete = r_init;
  assign app_wdf_rdy         = r_wdf_rdy;
  assign app_rd_data         = r_rdata;
  assign app_rd_data_valid   = r_rd_vld;
  assign app_rd_data_end     = r_rd_vld;

  assign axi_awaddr  = r_addr;
  assign axi_awlen   = 8'd0;
  assign axi_awsize  = SIZE;
  assign axi_awburst = 2'b01;
  assign axi_awvalid = r_awvalid;
  assign axi_wdata   = r_wdata;
  assign axi_wstrb   = ~r_mask;
  assign axi_wlast   = r_wvalid;
  assign axi_wvalid  = r_wvalid;
  assign axi_bready  = r_bready;
  assign axi_araddr  = r_addr;
  assign axi_arlen   = 8'd0;
  assign axi_arsize  = SIZE;
  assign axi_arburst = 2'b01;
  assign axi_arvalid = r_arvalid;
  assign axi_rready  = r_rready;

`ifdef NATIVE_TO_AXI4_RESP_CHECK_EN
  assign resp_err = r_resp_err;
`else
  assign resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_native_to_axi4_master.sv
// Bench for native_to_axi4_master: table of single transactions plus hand
// sequences for unsupported commands, back-to-back commands, error flag and
// mid-transaction reset. A negedge-driven AXI slave checks every handshake
// against scoreboard queues filled when the stimulus is issued.
module tb_native_to_axi4_master;
  localparam int AW = 27;
  localparam int DW = 256;
  localparam int SW = DW / 8;
`ifdef NATIVE_TO_AXI4_RESP_CHECK_EN
  localparam bit EXP_ERR = 1'b1;
`else
  localparam bit EXP_ERR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstn;
  logic [AW-1:0] app_addr;
  logic [2:0]    app_cmd;
  logic          app_en, app_rdy, init_calib_complete;
  logic [DW-1:0] app_wdf_data;
  logic [SW-1:0] app_wdf_mask;
  logic          app_wdf_wren, app_wdf_end, app_wdf_rdy;
  logic [DW-1:0] app_rd_data;
  logic          app_rd_data_valid, app_rd_data_end;
  logic [AW-1:0] axi_awaddr, axi_araddr;
  logic [7:0]    axi_awlen, axi_arlen;
  logic [2:0]    axi_awsize, axi_arsize;
  logic [1:0]    axi_awburst, axi_arburst;
  logic          axi_awvalid, axi_wvalid, axi_wlast, axi_bready, axi_arvalid, axi_rready;
  logic [DW-1:0] axi_wdata;
  logic [SW-1:0] axi_wstrb;
  logic          axi_awready = 1'b0, axi_wready = 1'b0, axi_bvalid = 1'b0;
  logic          axi_arready = 1'b0, axi_rvalid = 1'b0, axi_rlast = 1'b0;
  logic [1:0]    axi_bresp = 2'b00, axi_rresp = 2'b00;
  logic [DW-1:0] axi_rdata = '0;
  logic          resp_err;

  native_to_axi4_master dut (
    .axi_aclk(clk), .axi_resetn(rstn),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
    .init_calib_complete(init_calib_complete),
    .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask), .app_wdf_wren(app_wdf_wren),
    .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
    .app_rd_data_end(app_rd_data_end),
    .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize),
    .axi_awburst(axi_awburst), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize),
    .axi_arburst(axi_arburst), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
    .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int n_chk = 0, n_pass = 0;

  function automatic void chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk = n_chk + 1;
    if (act === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endfunction

  function automatic void miss(input string nm, input string what);
    n_chk = n_chk + 1;
    $display("FAIL %s: %s", nm, what);
  endfunction

  // scoreboard
  logic [AW-1:0] q_aw[$], q_ar[$];
  logic [DW-1:0] q_wd[$], q_rd[$];
  logic [SW-1:0] q_ws[$];

  // slave configuration
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0]    bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  logic [DW-1:0] rdata_cfg = '0;

  // slave state
  int awc = 0, wc = 0, bc = 0, arc = 0, rc = 0;
  bit aw_got = 0, w_got = 0, ar_got = 0, b_pend = 0, r_pend = 0;
  int b_cnt = 0, b_hs_cyc = -1, r_hs_cyc = -1;
  bit prev_rdv = 0, watch = 0, saw_valid = 0;

  // AXI slave + monitor: a ready/valid raised here while the other side is
  // already high means the handshake lands on the next rising edge.
  always @(negedge clk) begin
    if (!rstn) begin
      axi_awready = 0; axi_wready = 0; axi_bvalid = 0; axi_arready = 0; axi_rvalid = 0;
      awc = 0; wc = 0; bc = 0; arc = 0; rc = 0;
      aw_got = 0; w_got = 0; ar_got = 0; b_pend = 0; r_pend = 0; prev_rdv = 0;
    end else begin
      if (axi_awready) begin axi_awready = 0; aw_got = 1; end
      else if (axi_awvalid) begin
        if (awc >= aw_dly) begin
          axi_awready = 1; awc = 0;
          if (q_aw.size() == 0) miss("aw_unexpected", "AW handshake with none expected");
          else chk("awaddr", axi_awaddr, q_aw.pop_front());
          chk("awlen", axi_awlen, 0); chk("awsize", axi_awsize, 5); chk("awburst", axi_awburst, 1);
        end else awc++;
      end
      if (axi_wready) begin axi_wready = 0; w_got = 1; end
      else if (axi_wvalid) begin
        if (wc >= w_dly) begin
          axi_wready = 1; wc = 0;
          if (q_wd.size() == 0) miss("w_unexpected", "W handshake with none expected");
          else begin chk("wdata", axi_wdata, q_wd.pop_front()); chk("wstrb", axi_wstrb, q_ws.pop_front()); end
          chk("wlast", axi_wlast, 1);
        end else wc++;
      end
      if (b_pend) begin axi_bvalid = 0; b_pend = 0; b_cnt++; end
      else if (axi_bvalid) begin
        if (axi_bready) begin b_pend = 1; b_hs_cyc = cyc + 1; end
      end else if (aw_got && w_got) begin
        if (bc >= b_dly) begin
          axi_bvalid = 1; axi_bresp = bresp_cfg; aw_got = 0; w_got = 0; bc = 0;
          if (axi_bready) begin b_pend = 1; b_hs_cyc = cyc + 1; end
        end else bc++;
      end
      if (axi_arready) begin axi_arready = 0; ar_got = 1; end
      else if (axi_arvalid) begin
        if (arc >= ar_dly) begin
          axi_arready = 1; arc = 0;
          if (q_ar.size() == 0) miss("ar_unexpected", "AR handshake with none expected");
          else chk("araddr", axi_araddr, q_ar.pop_front());
          chk("arlen", axi_arlen, 0); chk("arsize", axi_arsize, 5); chk("arburst", axi_arburst, 1);
        end else arc++;
      end
      if (r_pend) begin axi_rvalid = 0; r_pend = 0; end
      else if (axi_rvalid) begin
        if (axi_rready) begin r_pend = 1; r_hs_cyc = cyc + 1; end
      end else if (ar_got) begin
        if (rc >= r_dly) begin
          axi_rvalid = 1; axi_rdata = rdata_cfg; axi_rresp = rresp_cfg; ar_got = 0; rc = 0;
          if (axi_rready) begin r_pend = 1; r_hs_cyc = cyc + 1; end
        end else rc++;
      end
      if (app_rd_data_valid) begin
        if (q_rd.size() == 0) miss("rd_unexpected", "read data returned with none expected");
        else chk("rd_data", app_rd_data, q_rd.pop_front());
        chk("rd_end", app_rd_data_end, 1);
        chk("rd_latency", cyc, r_hs_cyc);
        chk("rd_pulse", prev_rdv, 0);
      end
      prev_rdv = app_rd_data_valid;
    end
    if (!watch) saw_valid = 0;
    else if (axi_awvalid | axi_wvalid | axi_arvalid) saw_valid = 1;
  end

  task automatic issue(input logic [2:0] cmd, input logic [AW-1:0] addr,
                       input logic [DW-1:0] data, input logic [SW-1:0] mask);
    int n;
    @(negedge clk);
    app_en = 1; app_cmd = cmd; app_addr = addr; app_wdf_data = data; app_wdf_mask = mask;
    n = 0;
    while (!app_rdy && n < 200) begin @(negedge clk); n++; end
    if (!app_rdy) miss("accept_timeout", "app_rdy never rose");
    @(negedge clk); app_en = 0;
    if (cmd == 3'd0) begin
      app_wdf_wren = 1; n = 0;
      while (!app_wdf_rdy && n < 200) begin @(negedge clk); n++; end
      if (!app_wdf_rdy) miss("wdf_timeout", "app_wdf_rdy never rose");
      @(negedge clk); app_wdf_wren = 0;
    end
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    do begin @(negedge clk); n++; end while (!app_rdy && n < 300);
    if (!app_rdy) miss(nm, "transaction did not return to idle");
    @(negedge clk);
  endtask

  function automatic int sb_left();
    return q_aw.size() + q_wd.size() + q_ws.size() + q_ar.size() + q_rd.size();
  endfunction

  typedef struct {
    logic [2:0]    cmd;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;  // write data, or read data the slave returns
    logic [SW-1:0] mask;
    int aw_d, w_d, b_d, ar_d, r_d;
  } vec_t;

  vec_t tv[6];

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int b0, n;
    logic [DW-1:0] all1;
    all1 = '1;
    tv[0] = '{3'd0, 27'h100, 256'hDEADBEEF_CAFEF00D, 32'h0000_000F, 0, 3, 1, 0, 0};
    tv[1] = '{3'd1, 27'h200, 256'hA5, 32'h0, 0, 0, 0, 0, 4};
    tv[2] = '{3'd0, 27'h3C0, {8{32'h1234_5678}}, 32'hFFFF_0000, 4, 0, 2, 0, 0};
    tv[3] = '{3'd0, 27'h7FF_FFFF, all1, 32'hFFFF_FFFF, 0, 0, 0, 0, 0};
    tv[4] = '{3'd1, 27'h0, {8{32'h8765_4321}}, 32'h0, 0, 0, 0, 3, 0};
    tv[5] = '{3'd1, 27'h7FF_FFE0, all1, 32'h0, 0, 0, 0, 0, 1};

    rstn = 0; app_en = 0; app_cmd = 0; app_addr = 0; app_wdf_data = 0; app_wdf_mask = 0;
    app_wdf_wren = 0; app_wdf_end = 0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", {axi_awvalid, axi_wvalid, axi_arvalid, axi_bready, axi_rready, app_rdy,
                       app_wdf_rdy, init_calib_complete, app_rd_data_valid, app_rd_data_end, resp_err}, 0);
    chk("reset_addr", axi_awaddr, 0);
    chk("reset_rdata", app_rd_data, 0);
    #2 rstn = 1;
    #1 chk("calib_before_edge", init_calib_complete, 0);
    @(negedge clk);
    chk("calib_after_1", init_calib_complete, 1);
    chk("rdy_after_1", app_rdy, 1);

    // table-driven single transactions
    for (int i = 0; i < 6; i++) begin
      aw_dly = tv[i].aw_d; w_dly = tv[i].w_d; b_dly = tv[i].b_d; ar_dly = tv[i].ar_d; r_dly = tv[i].r_d;
      b0 = b_cnt;
      if (tv[i].cmd == 3'd0) begin
        q_aw.push_back(tv[i].addr); q_wd.push_back(tv[i].data); q_ws.push_back(~tv[i].mask);
      end else begin
        q_ar.push_back(tv[i].addr); q_rd.push_back(tv[i].data); rdata_cfg = tv[i].data;
      end
      issue(tv[i].cmd, tv[i].addr, tv[i].data, tv[i].mask);
      wait_idle("vec_idle_timeout");
      if (tv[i].cmd == 3'd0) chk("vec_bcount", b_cnt, b0 + 1);
      chk("vec_sb_drained", sb_left(), 0);
      chk("vec_resp_err", resp_err, 0);
    end

    // unsupported command: accepted, no AXI traffic, ready again next cycle
    watch = 1;
    issue(3'd3, 27'h55, 0, 0);
    chk("cmd3_rdy_next", app_rdy, 1);
    repeat (10) @(negedge clk);
    chk("cmd3_no_axi", saw_valid, 0);
    watch = 0;

    // back-to-back write then read, app_en held high throughout
    aw_dly = 2; w_dly = 2; b_dly = 3; ar_dly = 0; r_dly = 1; rdata_cfg = 256'h77;
    q_aw.push_back(27'h440); q_wd.push_back(256'h99); q_ws.push_back(~32'h0);
    q_ar.push_back(27'h480); q_rd.push_back(256'h77);
    b_hs_cyc = -1;
    @(negedge clk);
    app_en = 1; app_cmd = 0; app_addr = 27'h440; app_wdf_data = 256'h99; app_wdf_mask = 0;
    n = 0;
    while (!app_rdy && n < 200) begin @(negedge clk); n++; end
    @(negedge clk);
    app_cmd = 1; app_addr = 27'h480; app_wdf_wren = 1;
    @(negedge clk); app_wdf_wren = 0;
    n = 0;
    while (!app_rdy && n < 200) begin @(negedge clk); n++; end
    if (!app_rdy) miss("b2b_timeout", "app_rdy never returned after write");
    chk("b2b_rdy_after_b", b_hs_cyc, cyc);
    chk("b2b_read_not_issued", q_ar.size(), 1);
    @(negedge clk); app_en = 0;
    wait_idle("b2b_read_timeout");
    chk("b2b_sb_drained", sb_left(), 0);

    // error response: sticky when the check is built in, ignored otherwise
    aw_dly = 0; w_dly = 0; b_dly = 0; r_dly = 0; bresp_cfg = 2'b10;
    q_aw.push_back(27'h10); q_wd.push_back(256'h1); q_ws.push_back(~32'h0);
    issue(3'd0, 27'h10, 256'h1, 0);
    wait_idle("err_wr_timeout");
    chk("err_after_bresp", resp_err, EXP_ERR);
    bresp_cfg = 2'b00; rdata_cfg = 256'h3;
    q_ar.push_back(27'h20); q_rd.push_back(256'h3);
    issue(3'd1, 27'h20, 0, 0);
    wait_idle("err_rd_timeout");
    chk("err_sticky", resp_err, EXP_ERR);

    // reset while AW/W are pending
    aw_dly = 50; w_dly = 50;
    q_aw.push_back(27'h600); q_wd.push_back(256'h5); q_ws.push_back(~32'h0);
    issue(3'd0, 27'h600, 256'h5, 0);
    n = 0;
    while (!axi_awvalid && n < 20) begin @(negedge clk); n++; end
    chk("rst_aw_pending", axi_awvalid, 1);
    #2 rstn = 0;
    #1 chk("rst_mid_ctrl", {axi_awvalid, axi_wvalid, axi_arvalid, axi_bready, axi_rready, app_rdy,
                            app_wdf_rdy, init_calib_complete, app_rd_data_valid, app_rd_data_end, resp_err}, 0);
    chk("rst_mid_addr", axi_awaddr, 0);
    chk("rst_mid_wdata", axi_wdata, 0);
    q_aw.delete(); q_wd.delete(); q_ws.delete();
    aw_dly = 0; w_dly = 0;
    @(negedge clk);
    #2 rstn = 1;
    @(negedge clk);
    chk("rst_calib_1", init_calib_complete, 1);
    watch = 1;
    repeat (20) @(negedge clk);
    chk("rst_no_residual", saw_valid, 0);
    chk("rst_rdy", app_rdy, 1);
    watch = 0;

    // read error response after reset
    rresp_cfg = 2'b10; rdata_cfg = 256'hBEEF;
    q_ar.push_back(27'h30); q_rd.push_back(256'hBEEF);
    issue(3'd1, 27'h30, 0, 0);
    wait_idle("rresp_timeout");
    chk("err_after_rresp", resp_err, EXP_ERR);
    chk("final_sb_drained", sb_left(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
